// File: rtl/ocp_slave_mem.sv
// OCP slave in front of a 2**ADDR_WIDTH-word memory: posted/non-posted writes and burst reads.
// Define OCP_SLAVE_WRAP_EN to support WRAP bursts; when it is undefined, WRAP requests get a single ERR beat.
module ocp_slave_mem #(
  parameter int TAGI_WIDTH = 5,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              m_cmd,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [BLEN_WIDTH-1:0]   m_burst_length,
  input  logic [2:0]              m_burst_seq,
  input  logic [TAGI_WIDTH-1:0]   m_tagid,
  input  logic [DATA_WIDTH-1:0]   m_data,
  input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
  input  logic                    m_data_valid,
  input  logic                    m_data_last,
  input  logic                    m_resp_accept,
  output logic                    s_cmd_accept,
  output logic                    s_data_accept,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic [1:0]              s_resp,
  output logic                    s_resp_last,
  output logic [TAGI_WIDTH-1:0]   s_tagid
);

  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_WRNP = 3'b101;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  localparam logic [2:0] SEQ_INCR  = 3'b000;
`ifdef OCP_SLAVE_WRAP_EN
  localparam logic [2:0] SEQ_WRAP  = 3'b010;
`endif

  localparam logic [BLEN_WIDTH-1:0] ONE_BEAT  = BLEN_WIDTH'(1);
  localparam logic [BLEN_WIDTH-1:0] TWO_BEATS = BLEN_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RDATA, ST_RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, addr_inc;
  logic [BLEN_WIDTH-1:0] rem_q, rem_nxt, req_len;
  logic [TAGI_WIDTH-1:0] tag_q, tag_nxt;
  logic                  err_q, err_nxt;
  logic                  nonposted_q, nonposted_nxt;
  logic [DATA_WIDTH-1:0] s_data_nxt;
  logic [1:0]            s_resp_nxt;
  logic                  s_resp_last_nxt;
  logic [TAGI_WIDTH-1:0] s_tagid_nxt;
  logic                  cmd_fire, wr_en, seq_ok, req_ok, last_mismatch;

  assign cmd_fire = s_cmd_accept && (m_cmd != CMD_IDLE);
  assign wr_en    = (state == ST_WDATA) && s_data_accept && m_data_valid;

  always_comb begin
    req_len = (m_burst_length == '0) ? ONE_BEAT : m_burst_length;
    seq_ok  = (m_burst_seq == SEQ_INCR);
`ifdef OCP_SLAVE_WRAP_EN
    // WRAP needs a power-of-two length so the wrap boundary is a simple bit mask.
    if (m_burst_seq == SEQ_WRAP) seq_ok = ((req_len & (req_len - ONE_BEAT)) == '0);
`endif
    req_ok = seq_ok && (m_cmd inside {CMD_WR, CMD_WRNP, CMD_RD});
  end

`ifdef OCP_SLAVE_WRAP_EN
  logic                  wrap_q;
  logic [ADDR_WIDTH-1:0] wrap_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q      <= 1'b0;
      wrap_mask_q <= '0;
    end else if (cmd_fire) begin
      wrap_q      <= (m_burst_seq == SEQ_WRAP);
      wrap_mask_q <= ADDR_WIDTH'(req_len - ONE_BEAT);
    end
  end
`endif

  always_comb begin
    addr_inc = addr_q + ADDR_ONE;
`ifdef OCP_SLAVE_WRAP_EN
    if (wrap_q) addr_inc = (addr_q & ~wrap_mask_q) | ((addr_q + ADDR_ONE) & wrap_mask_q);
`endif
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt       = state;
    addr_nxt        = addr_q;
    rem_nxt         = rem_q;
    tag_nxt         = tag_q;
    err_nxt         = err_q;
    nonposted_nxt   = nonposted_q;
    s_data_nxt      = s_data;
    s_resp_nxt      = s_resp;
    s_resp_last_nxt = s_resp_last;
    s_tagid_nxt     = s_tagid;
    last_mismatch   = 1'b0;
    unique case (state)
      ST_IDLE: if (cmd_fire) begin
        addr_nxt      = m_addr;
        rem_nxt       = req_len;
        tag_nxt       = m_tagid;
        err_nxt       = 1'b0;
        nonposted_nxt = (m_cmd == CMD_WRNP);
        if (!req_ok) begin
          state_nxt       = ST_RESP;
          s_resp_nxt      = RESP_ERR;
          s_resp_last_nxt = 1'b1;
          s_tagid_nxt     = m_tagid;
        end else if (m_cmd == CMD_RD) begin
          state_nxt       = ST_RDATA;
          s_resp_nxt      = RESP_DVA;
          s_data_nxt      = mem[m_addr];
          s_tagid_nxt     = m_tagid;
          s_resp_last_nxt = (req_len == ONE_BEAT);
        end else begin
          state_nxt = ST_WDATA;
        end
      end
      ST_WDATA: if (wr_en) begin
        last_mismatch = (m_data_last != (rem_q == ONE_BEAT));
        addr_nxt      = addr_inc;
        rem_nxt       = rem_q - ONE_BEAT;
        err_nxt       = err_q | last_mismatch;
        if (rem_q == ONE_BEAT) begin
          if (nonposted_q) begin
            state_nxt       = ST_RESP;
            s_resp_nxt      = (err_q || last_mismatch) ? RESP_ERR : RESP_DVA;
            s_resp_last_nxt = 1'b1;
            s_tagid_nxt     = tag_q;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_RDATA: if (m_resp_accept) begin
        if (rem_q == ONE_BEAT) begin
          state_nxt       = ST_IDLE;
          s_resp_nxt      = RESP_NULL;
          s_resp_last_nxt = 1'b0;
        end else begin
          addr_nxt        = addr_inc;
          rem_nxt         = rem_q - ONE_BEAT;
          s_data_nxt      = mem[addr_inc];
          s_resp_last_nxt = (rem_q == TWO_BEATS);
        end
      end
      ST_RESP: if (m_resp_accept) begin
        state_nxt       = ST_IDLE;
        s_resp_nxt      = RESP_NULL;
        s_resp_last_nxt = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      s_cmd_accept  <= 1'b0;
      s_data_accept <= 1'b0;
      s_data        <= '0;
      s_resp        <= RESP_NULL;
      s_resp_last   <= 1'b0;
      s_tagid       <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      tag_q         <= '0;
      err_q         <= 1'b0;
      nonposted_q   <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_cmd_accept  <= (state_nxt == ST_IDLE);
      s_data_accept <= (state_nxt == ST_WDATA);
      s_data        <= s_data_nxt;
      s_resp        <= s_resp_nxt;
      s_resp_last   <= s_resp_last_nxt;
      s_tagid       <= s_tagid_nxt;
      addr_q        <= addr_nxt;
      rem_q         <= rem_nxt;
      tag_q         <= tag_nxt;
      err_q         <= err_nxt;
      nonposted_q   <= nonposted_nxt;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (m_data_byteen[b]) mem[addr_q][8*b +: 8] <= m_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Self-checking bench for ocp_slave_mem: directed vector table, hand sequences, and random traffic
// checked against a word-array memory model. Honours OCP_SLAVE_WRAP_EN the same way as the design.
`timescale 1ns/1ps
module tb_ocp_slave_mem;

  localparam int TAGI_WIDTH = 5;
  localparam int BLEN_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_RDEX = 3'b011;
  localparam logic [2:0] CMD_WRNP = 3'b101;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b11;
  localparam logic [2:0] SEQ_INCR = 3'b000;
  localparam logic [2:0] SEQ_WRAP = 3'b010;
`ifdef OCP_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic                  clk, rst_n;
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [BLEN_WIDTH-1:0] m_burst_length;
  logic [2:0]            m_burst_seq;
  logic [TAGI_WIDTH-1:0] m_tagid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [3:0]            m_data_byteen;
  logic                  m_data_valid, m_data_last, m_resp_accept;
  logic                  s_cmd_accept, s_data_accept, s_resp_last;
  logic [DATA_WIDTH-1:0] s_data;
  logic [1:0]            s_resp;
  logic [TAGI_WIDTH-1:0] s_tagid;

  ocp_slave_mem #(
    .TAGI_WIDTH(TAGI_WIDTH), .BLEN_WIDTH(BLEN_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_burst_length(m_burst_length),
    .m_burst_seq(m_burst_seq), .m_tagid(m_tagid),
    .m_data(m_data), .m_data_byteen(m_data_byteen), .m_data_valid(m_data_valid),
    .m_data_last(m_data_last), .m_resp_accept(m_resp_accept),
    .s_cmd_accept(s_cmd_accept), .s_data_accept(s_data_accept), .s_data(s_data),
    .s_resp(s_resp), .s_resp_last(s_resp_last), .s_tagid(s_tagid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] got_data;

  typedef struct {
    logic [2:0] cmd;
    logic [4:0] addr;
    logic [3:0] len;
    logic [2:0] seq;
    logic [4:0] tag;
    logic [3:0] be;
    logic [31:0] base;
    int         last_idx;
    logic [1:0] exp_resp;
    int         exp_beats;
    int         stall_beat;
    int         stall_len;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of beat i of a burst, from plain modular arithmetic.
  function automatic int beat_addr(int start, int len, logic [2:0] seq, int i);
    int base;
    if (seq == SEQ_WRAP) begin
      base = start - (start % len);
      return base + ((start - base + i) % len);
    end
    return (start + i) % DEPTH;
  endfunction

  function automatic bit req_supported(logic [2:0] cmd, int eff_len, logic [2:0] seq);
    bit s_ok;
    s_ok = (seq == SEQ_INCR) ||
           (WRAP_EN && seq == SEQ_WRAP && (eff_len inside {1, 2, 4, 8, 16}));
    return s_ok && (cmd == CMD_WR || cmd == CMD_WRNP || cmd == CMD_RD);
  endfunction

  task automatic model_expect(input logic [2:0] cmd, input int eff_len, input logic [2:0] seq,
                              input int last_idx, output logic [1:0] resp, output int beats);
    if (!req_supported(cmd, eff_len, seq)) begin
      resp = R_ERR; beats = 1;
    end else if (cmd == CMD_RD) begin
      resp = R_DVA; beats = eff_len;
    end else if (cmd == CMD_WR) begin
      resp = R_NULL; beats = 0;
    end else begin
      resp = (last_idx == eff_len - 1) ? R_DVA : R_ERR; beats = 1;
    end
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] len,
                       input logic [2:0] seq, input logic [4:0] tag);
    int w = 0;
    while (s_cmd_accept !== 1'b1 && w < 20) begin step(); w++; end
    if (w == 20) check("cmd_accept_wait", {63'd0, s_cmd_accept}, 64'd1);
    m_cmd = cmd; m_addr = addr; m_burst_length = len; m_burst_seq = seq; m_tagid = tag;
    step();
    m_cmd = CMD_IDLE;
    check("cmd_accept_drop", {63'd0, s_cmd_accept}, 64'd0);
  endtask

  task automatic write_data(input logic [4:0] addr, input int eff_len, input logic [2:0] seq,
                            input logic [31:0] base, input logic [3:0] be, input int last_idx,
                            input bit gaps);
    int w;
    int a;
    logic [31:0] d;
    for (int i = 0; i < eff_len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin m_data_valid = 1'b0; step(); end
      d = base + 32'(i);
      m_data = d; m_data_byteen = be; m_data_valid = 1'b1; m_data_last = (i == last_idx);
      w = 0;
      while (s_data_accept !== 1'b1 && w < 20) begin step(); w++; end
      if (w == 20) check("data_accept_wait", {63'd0, s_data_accept}, 64'd1);
      step();
      a = beat_addr(int'(addr), eff_len, seq, i);
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    m_data_valid = 1'b0; m_data_last = 1'b0;
    check("data_accept_end", {63'd0, s_data_accept}, 64'd0);
  endtask

  task automatic collect(input int nbeats, input logic [1:0] resp, input logic [4:0] tag,
                         input bit is_read, input logic [4:0] addr, input int eff_len,
                         input logic [2:0] seq, input int stall_beat, input int stall_len);
    int w = 0;
    logic [31:0] exp_d;
    if (nbeats == 0) begin
      check("posted_no_resp", {62'd0, s_resp}, {62'd0, R_NULL});
      check("posted_idle", {63'd0, s_cmd_accept}, 64'd1);
      return;
    end
    while (s_resp === R_NULL && w < 20) begin step(); w++; end
    for (int b = 0; b < nbeats; b++) begin
      exp_d = is_read ? ref_mem[beat_addr(int'(addr), eff_len, seq, b)] : 32'd0;
      check("resp_code", {62'd0, s_resp}, {62'd0, resp});
      check("resp_last", {63'd0, s_resp_last}, {63'd0, (b == nbeats - 1)});
      check("resp_tag", {59'd0, s_tagid}, {59'd0, tag});
      if (is_read) check("rd_data", {32'd0, s_data}, {32'd0, exp_d});
      got_data = s_data;
      if (b == stall_beat && stall_len > 0) begin
        m_resp_accept = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          check("stall_resp", {62'd0, s_resp}, {62'd0, resp});
          check("stall_last", {63'd0, s_resp_last}, {63'd0, (b == nbeats - 1)});
          if (is_read) check("stall_data", {32'd0, s_data}, {32'd0, exp_d});
        end
        m_resp_accept = 1'b1;
      end
      step();
    end
    check("resp_null_after", {62'd0, s_resp}, {62'd0, R_NULL});
    check("idle_after", {63'd0, s_cmd_accept}, 64'd1);
  endtask

  task automatic run_txn(input vec_t v, input bit gaps);
    int eff_len;
    eff_len = (v.len == 0) ? 1 : int'(v.len);
    issue(v.cmd, v.addr, v.len, v.seq, v.tag);
    if (req_supported(v.cmd, eff_len, v.seq) && v.cmd != CMD_RD)
      write_data(v.addr, eff_len, v.seq, v.base, v.be, v.last_idx, gaps);
    collect(v.exp_beats, v.exp_resp, v.tag, v.cmd == CMD_RD && v.exp_resp == R_DVA,
            v.addr, eff_len, v.seq, v.stall_beat, v.stall_len);
  endtask

  function automatic vec_t mk(logic [2:0] cmd, logic [4:0] addr, logic [3:0] len, logic [2:0] seq,
                              logic [4:0] tag, logic [3:0] be, logic [31:0] base, int last_idx,
                              logic [1:0] exp_resp, int exp_beats, int stall_beat, int stall_len);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.len = len; v.seq = seq; v.tag = tag; v.be = be;
    v.base = base; v.last_idx = last_idx; v.exp_resp = exp_resp; v.exp_beats = exp_beats;
    v.stall_beat = stall_beat; v.stall_len = stall_len;
    return v;
  endfunction

  initial begin
    vec_t v;
    int eff_len;

    rst_n = 1'b0; m_cmd = CMD_IDLE; m_addr = '0; m_burst_length = '0; m_burst_seq = SEQ_INCR;
    m_tagid = '0; m_data = '0; m_data_byteen = '0; m_data_valid = 1'b0; m_data_last = 1'b0;
    m_resp_accept = 1'b1;

    // Reset state
    #12;
    check("rst_cmd_accept", {63'd0, s_cmd_accept}, 64'd0);
    check("rst_data_accept", {63'd0, s_data_accept}, 64'd0);
    check("rst_resp", {62'd0, s_resp}, {62'd0, R_NULL});
    check("rst_resp_last", {63'd0, s_resp_last}, 64'd0);
    check("rst_data", {32'd0, s_data}, 64'd0);
    check("rst_tag", {59'd0, s_tagid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("cmd_accept_before_edge", {63'd0, s_cmd_accept}, 64'd0);
    step();
    check("cmd_accept_after_release", {63'd0, s_cmd_accept}, 64'd1);

    // Preload the whole memory so every later read has a defined reference.
    for (int k = 0; k < 4; k++)
      run_txn(mk(CMD_WR, 5'(8*k), 4'd8, SEQ_INCR, 5'd0, 4'hF, $urandom, 7, R_NULL, 0, -1, 0), 1'b0);

    // Directed vector table
    vecs[0]  = mk(CMD_WR,   5'd3,  4'd4, SEQ_INCR, 5'd0,  4'hF, 32'hA0, 3,  R_NULL, 0, -1, 0);
    vecs[1]  = mk(CMD_RD,   5'd3,  4'd4, SEQ_INCR, 5'd7,  4'h0, 32'h0,  0,  R_DVA,  4, -1, 0);
    vecs[2]  = mk(CMD_WRNP, 5'd31, 4'd2, SEQ_INCR, 5'd2,  4'hF, 32'hB0, 1,  R_DVA,  1, -1, 0);
    vecs[3]  = mk(CMD_RD,   5'd31, 4'd2, SEQ_INCR, 5'd3,  4'h0, 32'h0,  0,  R_DVA,  2, -1, 0);
`ifdef OCP_SLAVE_WRAP_EN
    vecs[4]  = mk(CMD_RD,   5'd6,  4'd4, SEQ_WRAP, 5'd4,  4'h0, 32'h0,  0,  R_DVA,  4, -1, 0);
`else
    vecs[4]  = mk(CMD_RD,   5'd6,  4'd4, SEQ_WRAP, 5'd4,  4'h0, 32'h0,  0,  R_ERR,  1, -1, 0);
`endif
    vecs[5]  = mk(CMD_WRNP, 5'd12, 4'd3, SEQ_INCR, 5'd5,  4'hF, 32'hC0, 1,  R_ERR,  1, -1, 0);
    vecs[6]  = mk(CMD_RD,   5'd12, 4'd3, SEQ_INCR, 5'd6,  4'h0, 32'h0,  0,  R_DVA,  3, -1, 0);
    vecs[7]  = mk(CMD_RD,   5'd3,  4'd4, SEQ_INCR, 5'd8,  4'h0, 32'h0,  0,  R_DVA,  4, 1,  3);
    vecs[8]  = mk(CMD_RDEX, 5'd3,  4'd4, SEQ_INCR, 5'd9,  4'h0, 32'h0,  0,  R_ERR,  1, -1, 0);
    vecs[9]  = mk(CMD_RD,   5'd3,  4'd4, SEQ_INCR, 5'd10, 4'h0, 32'h0,  0,  R_DVA,  4, -1, 0);
    vecs[10] = mk(CMD_RD,   5'd8,  4'd0, SEQ_INCR, 5'd11, 4'h0, 32'h0,  0,  R_DVA,  1, -1, 0);
    vecs[11] = mk(CMD_RD,   5'd8,  4'd3, SEQ_WRAP, 5'd12, 4'h0, 32'h0,  0,  R_ERR,  1, -1, 0);
    vecs[12] = mk(CMD_RD,   5'd8,  4'd2, 3'b001,   5'd13, 4'h0, 32'h0,  0,  R_ERR,  1, -1, 0);
    vecs[13] = mk(CMD_WR,   5'd9,  4'd2, SEQ_INCR, 5'd14, 4'hF, 32'hD0, 0,  R_NULL, 0, -1, 0);
    for (int i = 0; i < 14; i++) run_txn(vecs[i], 1'b0);

    // Explicit values for the read-back of the first burst and the wrap order.
    run_txn(mk(CMD_RD, 5'd6, 4'd1, SEQ_INCR, 5'd1, 4'h0, 32'h0, 0, R_DVA, 1, -1, 0), 1'b0);
    check("word6_is_A3", {32'd0, got_data}, 64'hA3);
    run_txn(mk(CMD_RD, 5'd0, 4'd1, SEQ_INCR, 5'd1, 4'h0, 32'h0, 0, R_DVA, 1, -1, 0), 1'b0);
    check("word0_is_B1", {32'd0, got_data}, 64'hB1);

    // Byte-lane merge
    run_txn(mk(CMD_WR, 5'd10, 4'd1, SEQ_INCR, 5'd0, 4'hF, 32'hFFFFFFFF, 0, R_NULL, 0, -1, 0), 1'b0);
    run_txn(mk(CMD_WR, 5'd10, 4'd1, SEQ_INCR, 5'd0, 4'h3, 32'h00001234, 0, R_NULL, 0, -1, 0), 1'b0);
    run_txn(mk(CMD_RD, 5'd10, 4'd1, SEQ_INCR, 5'd1, 4'h0, 32'h0, 0, R_DVA, 1, -1, 0), 1'b0);
    check("byteen_merge", {32'd0, got_data}, 64'hFFFF1234);

    // Reset in the middle of a read burst
    issue(CMD_RD, 5'd3, 4'd4, SEQ_INCR, 5'd5);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_resp", {62'd0, s_resp}, {62'd0, R_NULL});
    check("midrst_cmd_accept", {63'd0, s_cmd_accept}, 64'd0);
    check("midrst_tag", {59'd0, s_tagid}, 64'd0);
    check("midrst_data", {32'd0, s_data}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("midrst_cmd_accept_back", {63'd0, s_cmd_accept}, 64'd1);
    check("midrst_resp_quiet", {62'd0, s_resp}, {62'd0, R_NULL});
    run_txn(mk(CMD_RD, 5'd3, 4'd4, SEQ_INCR, 5'd6, 4'h0, 32'h0, 0, R_DVA, 4, -1, 0), 1'b0);
    check("midrst_mem_intact", {32'd0, got_data}, 64'hA3);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      v.cmd = (r < 4) ? CMD_RD : (r < 6) ? CMD_WR : (r < 8) ? CMD_WRNP :
              (r == 8) ? 3'($urandom_range(3, 7)) : CMD_RD;
      if (v.cmd == 3'b101) v.cmd = CMD_RDEX;
      v.addr = 5'($urandom_range(0, 31));
      v.len  = 4'($urandom_range(0, 8));
      v.seq  = ($urandom_range(0, 3) == 0) ? SEQ_WRAP : SEQ_INCR;
      v.tag  = 5'($urandom_range(0, 31));
      v.be   = 4'($urandom_range(0, 15));
      v.base = $urandom;
      eff_len = (v.len == 0) ? 1 : int'(v.len);
      v.last_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, eff_len - 1) : eff_len - 1;
      v.stall_beat = $urandom_range(0, eff_len - 1);
      v.stall_len  = $urandom_range(0, 3);
      model_expect(v.cmd, eff_len, v.seq, v.last_idx, v.exp_resp, v.exp_beats);
      run_txn(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
